rule_serializer: RTL

Downstream neighbour of the port-group stage. It consumes the 512-bit match stream, where each beat packs 32 lanes of 16 bits and each lane holds a rule ID in its low RULE_AWIDTH bits (0 means an empty lane), together with one metadata record per packet. It drops the empty lanes and emits the surviving rule IDs one per cycle, in order, then issues the packet's metadata tagged with its rule count. It feeds the rule-verification / host-report path.

---
 rtl/rule_serializer_if.sv | 52 +++++
 rtl/rule_serializer.sv | 119 +++++++++++
 2 files changed

// File: rtl/rule_serializer_if.sv
// Stream bundle between the port-group stage, rule_serializer and the report path.
// slave = serializer view, master = upstream/downstream neighbours view.
package rule_serializer_pkg;
    typedef logic [63:0] metadata_t;
endpackage

interface rule_serializer_if;
    import rule_serializer_pkg::*;

    logic            in_match_sop;
    logic            in_match_eop;
    logic [511:0]    in_match_data;
    logic [5:0]      in_match_empty;
    logic            in_match_valid;
    logic            in_match_ready;
    logic            in_meta_valid;
    metadata_t       in_meta_data;
    logic            in_meta_ready;
    logic            out_rule_valid;
    logic [15:0]     out_rule_data;
    logic            out_rule_ready;
    logic            out_meta_valid;
    metadata_t       out_meta_data;
    logic [15:0]     out_meta_rule_cnt;
    logic            out_meta_ready;
    logic [31:0]     pkt_cnt;
    logic [31:0]     rule_cnt;

    modport slave (
        input  in_match_sop, in_match_eop, in_match_data, in_match_empty, in_match_valid,
        output in_match_ready,
        input  in_meta_valid, in_meta_data,
        output in_meta_ready,
        output out_rule_valid, out_rule_data,
        input  out_rule_ready,
        output out_meta_valid, out_meta_data, out_meta_rule_cnt,
        input  out_meta_ready,
        output pkt_cnt, rule_cnt
    );

    modport master (
        output in_match_sop, in_match_eop, in_match_data, in_match_empty, in_match_valid,
        input  in_match_ready,
        output in_meta_valid, in_meta_data,
        input  in_meta_ready,
        input  out_rule_valid, out_rule_data,
        output out_rule_ready,
        input  out_meta_valid, out_meta_data, out_meta_rule_cnt,
        output out_meta_ready,
        input  pkt_cnt, rule_cnt
    );
endinterface

// File: rtl/rule_serializer.sv
// Drops empty lanes of the 512-bit match stream and emits surviving rule IDs one per
// cycle, followed by the packet metadata tagged with its rule count.
//
// state | meaning
// IDLE  | waiting for packet metadata
// BEAT  | waiting for the next match beat
// SCAN  | emitting buffered rule IDs, lowest lane first
// META  | presenting the per-packet record
module rule_serializer #(
    parameter int RULE_AWIDTH = 13,
    parameter int LANES       = 32
) (
    input logic          clk,
    input logic          rst,
    rule_serializer_if.slave bus
);
    import rule_serializer_pkg::*;

    localparam int SEL_W = $clog2(LANES);
    localparam int HI_W  = 16 - RULE_AWIDTH;

    typedef enum logic [1:0] {IDLE, BEAT, SCAN, META} state_t;

    state_t                               state;
    logic                                 run;
    logic [LANES-1:0][RULE_AWIDTH-1:0]    lane_buf;
    logic [LANES-1:0]                     mask;
    logic [LANES-1:0]                     beat_mask;
    logic [LANES-1:0]                     mask_rest;
    logic                                 eop_q;
    metadata_t                            meta_q;
    logic [15:0]                          cnt_q;
    logic [31:0]                          pkt_q;
    logic [31:0]                          rule_q;
    logic [SEL_W-1:0]                     sel;
    logic [LANES*HI_W-1:0]                unused_hi;
    logic                                 unused_ok;

    always_comb begin
        beat_mask = '0;
        unused_hi = '0;
        for (int i = 0; i < LANES; i++) begin
            beat_mask[i] = |bus.in_match_data[16*i +: RULE_AWIDTH];
            unused_hi[i*HI_W +: HI_W] = bus.in_match_data[16*i+RULE_AWIDTH +: HI_W];
        end
    end

    assign unused_ok = ^{unused_hi, bus.in_match_sop, bus.in_match_empty};

    always_comb begin
        sel = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask[i]) sel = SEL_W'(i);
        end
    end

    // Clearing the lowest set bit; an all-zero remainder means the beat is drained.
    assign mask_rest = mask & (mask - LANES'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            run      <= 1'b0;
            lane_buf <= '0;
            mask     <= '0;
            eop_q    <= 1'b0;
            meta_q   <= '0;
            cnt_q    <= '0;
            pkt_q    <= '0;
            rule_q   <= '0;
        end else begin
            run <= 1'b1;
            case (state)
                IDLE: begin
                    if (bus.in_meta_valid && run) begin
                        meta_q <= bus.in_meta_data;
                        cnt_q  <= '0;
                        state  <= BEAT;
                    end
                end
                BEAT: begin
                    if (bus.in_match_valid) begin
                        for (int i = 0; i < LANES; i++)
                            lane_buf[i] <= bus.in_match_data[16*i +: RULE_AWIDTH];
                        mask  <= beat_mask;
                        eop_q <= bus.in_match_eop;
                        if (beat_mask != '0)      state <= SCAN;
                        else if (bus.in_match_eop) state <= META;
                    end
                end
                SCAN: begin
                    if (bus.out_rule_ready) begin
                        mask   <= mask_rest;
                        cnt_q  <= (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                        rule_q <= rule_q + 32'd1;
                        if (mask_rest == '0) state <= eop_q ? META : BEAT;
                    end
                end
                META: begin
                    if (bus.out_meta_ready) begin
                        pkt_q <= pkt_q + 32'd1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_meta_ready     = (state == IDLE) && run;
    assign bus.in_match_ready    = (state == BEAT);
    assign bus.out_rule_valid    = (state == SCAN);
    assign bus.out_rule_data     = (state == SCAN) ? 16'(lane_buf[sel]) : 16'd0;
    assign bus.out_meta_valid    = (state == META);
    assign bus.out_meta_data     = meta_q;
    assign bus.out_meta_rule_cnt = cnt_q;
    assign bus.pkt_cnt           = pkt_q;
    assign bus.rule_cnt          = rule_q;
endmodule
